// File: rtl/tts_sequencer.sv
// -----------------------------------------------------------------------------
// tts_sequencer
//
// Purpose
//    Produces the 4-bit TTS state sent on the DAQ link from a registered FSM.
//    Error and sync-lost indications are held in sticky latches. Buffer
//    occupancy is reduced to busy / overflow-warning flags with hysteresis.
//    Moves to a higher-priority state happen at once. Moves to a
//    lower-priority state wait until the current state has been held for
//    HOLD_CYCLES cycles. Entries into Error and SyncLost are counted.
//
// Ports
//    clk              in   1      sole clock
//    reset_n          in   1      asynchronous, active-low reset
//    link_up          in   1      DAQ link up; low forces Disconnected
//    error_in         in   1      OR of error sources
//    sync_lost_in     in   1      OR of trigger number/type mismatch sources
//    occupancy        in   OCC_W  DDR3 buffer fill level, unsigned
//    clear_sticky     in   1      pulse: clear the error/sync-lost latches
//    force_en         in   1      (TTS_FORCE_EN only) override the output state
//    force_state      in   4      (TTS_FORCE_EN only) value driven while forced
//    tts_state        out  4      0000 Disc, 1100 Error, 0010 SyncLost,
//                                 0100 Busy, 0001 OvfWarn, 1000 Ready
//    state_change     out  1      pulses in the cycle tts_state takes a new value
//    error_count      out  CNT_W  saturating count of entries into Error
//    sync_lost_count  out  CNT_W  saturating count of entries into SyncLost
//
// Configuration macro
//    TTS_FORCE_EN     adds force_en / force_state. The FSM keeps running
//                     underneath while the output is forced.
// -----------------------------------------------------------------------------
module tts_sequencer #(
   parameter int               HOLD_CYCLES = 1024,
   parameter int               OCC_W       = 16,
   parameter logic [OCC_W-1:0] WARN_HI     = 16'hC000,
   parameter logic [OCC_W-1:0] WARN_LO     = 16'hA000,
   parameter logic [OCC_W-1:0] BUSY_HI     = 16'hF000,
   parameter logic [OCC_W-1:0] BUSY_LO     = 16'hD000,
   parameter int               CNT_W       = 16
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             link_up,
   input  logic             error_in,
   input  logic             sync_lost_in,
   input  logic [OCC_W-1:0] occupancy,
   input  logic             clear_sticky,
`ifdef TTS_FORCE_EN
   input  logic             force_en,
   input  logic [3:0]       force_state,
`endif
   output logic [3:0]       tts_state,
   output logic             state_change,
   output logic [CNT_W-1:0] error_count,
   output logic [CNT_W-1:0] sync_lost_count
);

   // State encodings are the TTS codes, so the state register drives the
   // output directly.
   typedef enum logic [3:0] {
      DISC = 4'b0000,
      ERR  = 4'b1100,
      SYNC = 4'b0010,
      BUSY = 4'b0100,
      WARN = 4'b0001,
      RDY  = 4'b1000
   } state_t;

   localparam int             DW        = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
   localparam logic [DW-1:0]  DWELL_MAX = DW'(HOLD_CYCLES - 1);

   // Higher number = higher priority. DISC ranks lowest. It is left through
   // a separate rule, so its rank never decides a move.
   function automatic logic [2:0] rank(input state_t s);
      case (s)
         ERR:     rank = 3'd5;
         SYNC:    rank = 3'd4;
         BUSY:    rank = 3'd3;
         WARN:    rank = 3'd2;
         RDY:     rank = 3'd1;
         default: rank = 3'd0;
      endcase
   endfunction

   state_t           state_reg, state_next, req_state;
   logic [DW-1:0]    dwell_reg, dwell_next;
   logic             err_l_reg, err_l_next;
   logic             sync_l_reg, sync_l_next;
   logic             busy_f_reg, busy_f_next;
   logic             warn_f_reg, warn_f_next;
   logic             change_reg, change_next;
   logic [CNT_W-1:0] err_cnt_reg, err_cnt_next;
   logic [CNT_W-1:0] sync_cnt_reg, sync_cnt_next;

   // Sticky latches and hysteresis flags.
   always_comb begin
      // An active source always wins over a simultaneous clear.
      err_l_next  = error_in     | (err_l_reg  & ~clear_sticky);
      sync_l_next = sync_lost_in | (sync_l_reg & ~clear_sticky);

      busy_f_next = busy_f_reg;
      if (occupancy >= BUSY_HI)
         busy_f_next = 1'b1;
      else if (occupancy <= BUSY_LO)
         busy_f_next = 1'b0;

      warn_f_next = warn_f_reg;
      if (occupancy >= WARN_HI)
         warn_f_next = 1'b1;
      else if (occupancy <= WARN_LO)
         warn_f_next = 1'b0;
   end

   // Next-state logic and dwell counter.
   always_comb begin
      req_state = RDY;
      if (err_l_reg)
         req_state = ERR;
      else if (sync_l_reg)
         req_state = SYNC;
      else if (busy_f_reg)
         req_state = BUSY;
      else if (warn_f_reg)
         req_state = WARN;

      state_next = state_reg;
      if (!link_up)
         state_next = DISC;
      else if (state_reg == DISC)
         state_next = req_state;
      else if (rank(req_state) > rank(state_reg))
         state_next = req_state;
      // The dwell counter saturates at DWELL_MAX, so == works the same as >= here.
      else if ((rank(req_state) < rank(state_reg)) && (dwell_reg == DWELL_MAX))
         state_next = req_state;

      dwell_next = dwell_reg;
      if (state_next != state_reg)
         dwell_next = '0;
      else if (dwell_reg != DWELL_MAX)
         dwell_next = dwell_reg + DW'(1);

      // Counters advance with the entry edge, together with the state.
      err_cnt_next = err_cnt_reg;
      if ((state_next == ERR) && (state_reg != ERR) && (err_cnt_reg != '1))
         err_cnt_next = err_cnt_reg + CNT_W'(1);

      sync_cnt_next = sync_cnt_reg;
      if ((state_next == SYNC) && (state_reg != SYNC) && (sync_cnt_reg != '1))
         sync_cnt_next = sync_cnt_reg + CNT_W'(1);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_reg    <= DISC;
         dwell_reg    <= '0;
         err_l_reg    <= 1'b0;
         sync_l_reg   <= 1'b0;
         busy_f_reg   <= 1'b0;
         warn_f_reg   <= 1'b0;
         change_reg   <= 1'b0;
         err_cnt_reg  <= '0;
         sync_cnt_reg <= '0;
      end else begin
         state_reg    <= state_next;
         dwell_reg    <= dwell_next;
         err_l_reg    <= err_l_next;
         sync_l_reg   <= sync_l_next;
         busy_f_reg   <= busy_f_next;
         warn_f_reg   <= warn_f_next;
         change_reg   <= change_next;
         err_cnt_reg  <= err_cnt_next;
         sync_cnt_reg <= sync_cnt_next;
      end
   end

`ifdef TTS_FORCE_EN
   // A separate output register lets a forced value sit on the link while
   // the FSM keeps running. state_change then follows the visible value.
   logic [3:0] out_reg, out_next;

   always_comb begin
      out_next    = force_en ? force_state : state_next;
      change_next = (out_next != out_reg);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)
         out_reg <= 4'b0000;
      else
         out_reg <= out_next;
   end

   assign tts_state = out_reg;
`else
   always_comb begin
      change_next = (state_next != state_reg);
   end

   assign tts_state = state_reg;
`endif

   assign state_change    = change_reg;
   assign error_count     = err_cnt_reg;
   assign sync_lost_count = sync_cnt_reg;

endmodule
